// File: rtl/pipe_stage_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_regs
// Purpose  : Pipeline-register bank for a 5-stage ARM core. Holds the PC (F),
//            F/D, D/E, E/M and M/W registers for the hazard-relevant fields.
//            It also keeps per-stage valid bits and a saturating counter of
//            bubbles loaded into the E stage.
// Ports    : clk, rst_n                     - clock / async active-low reset
//            StallF, StallD, FlushD, FlushE - hazard unit controls
//            PCNextF, InstrF                - fetch-side inputs
//            RA1D, RA2D, WA3D, *D controls  - decoded fields of D instruction
//            CondExE                        - condition check result in E
//            PCF, InstrD                    - fetch / decode registers
//            RA1E, RA2E, WA3E/M/W, staged controls, BranchTakenE
//            ValidD/E/M/W                   - stage occupancy
//            BubbleCnt                      - E-stage bubble count
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_regs #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] PCNextF,
  input  logic [DATA_W-1:0] InstrF,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              PCSrcD,
  input  logic              BranchD,
  input  logic              CondExE,
  output logic [DATA_W-1:0] PCF,
  output logic [DATA_W-1:0] InstrD,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [3:0]        WA3E,
  output logic [3:0]        WA3M,
  output logic [3:0]        WA3W,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegE,
  output logic              MemWriteM,
  output logic              PCSrcW,
  output logic              BranchTakenE,
  output logic              ValidD,
  output logic              ValidE,
  output logic              ValidM,
  output logic              ValidW,
  output logic [CNT_W-1:0]  BubbleCnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Fetch / decode
  logic [DATA_W-1:0] pcf_q, pcf_d;
  logic [DATA_W-1:0] instr_d_q, instr_d_d;
  logic              valid_d_q, valid_d_d;

  // Decode / execute
  logic [3:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
  logic       regwrite_e_q, regwrite_e_d, memtoreg_e_q, memtoreg_e_d;
  logic       memwrite_e_q, memwrite_e_d, pcsrc_e_q, pcsrc_e_d;
  logic       branch_e_q, branch_e_d, valid_e_q, valid_e_d;

  // Execute / memory
  logic [3:0] wa3_m_q, wa3_m_d;
  logic       regwrite_m_q, regwrite_m_d, memwrite_m_q, memwrite_m_d;
  logic       pcsrc_m_q, pcsrc_m_d, valid_m_q, valid_m_d;

  // Memory / writeback
  logic [3:0] wa3_w_q, wa3_w_d;
  logic       regwrite_w_q, regwrite_w_d, pcsrc_w_q, pcsrc_w_d;
  logic       valid_w_q, valid_w_d;

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             bubble_e;

  // A bubble enters E either on an explicit flush or when D holds nothing.
  assign bubble_e = FlushE | ~valid_d_q;

  always_comb begin
    pcf_d     = StallF ? pcf_q : PCNextF;

    // Flush wins over stall so a squashed instruction cannot be held in D.
    instr_d_d = instr_d_q;
    valid_d_d = valid_d_q;
    if (FlushD) begin
      instr_d_d = '0;
      valid_d_d = 1'b0;
    end else if (!StallD) begin
      instr_d_d = InstrF;
      valid_d_d = 1'b1;
    end

    // Side-effecting controls are gated by ValidD so an empty D stage can
    // never write state once it reaches E.
    ra1_e_d      = RA1D;
    ra2_e_d      = RA2D;
    wa3_e_d      = WA3D;
    regwrite_e_d = RegWriteD & valid_d_q;
    memtoreg_e_d = MemtoRegD;
    memwrite_e_d = MemWriteD & valid_d_q;
    pcsrc_e_d    = PCSrcD & valid_d_q;
    branch_e_d   = BranchD;
    valid_e_d    = valid_d_q;
    if (FlushE) begin
      ra1_e_d      = '0;
      ra2_e_d      = '0;
      wa3_e_d      = '0;
      regwrite_e_d = 1'b0;
      memtoreg_e_d = 1'b0;
      memwrite_e_d = 1'b0;
      pcsrc_e_d    = 1'b0;
      branch_e_d   = 1'b0;
      valid_e_d    = 1'b0;
    end

    // Conditional execution suppresses side effects; destination still flows.
    wa3_m_d      = wa3_e_q;
    regwrite_m_d = regwrite_e_q & CondExE;
    memwrite_m_d = memwrite_e_q & CondExE;
    pcsrc_m_d    = pcsrc_e_q & CondExE;
    valid_m_d    = valid_e_q;

    wa3_w_d      = wa3_m_q;
    regwrite_w_d = regwrite_m_q;
    pcsrc_w_d    = pcsrc_m_q;
    valid_w_d    = valid_m_q;

    bubble_cnt_d = bubble_cnt_q;
    if (bubble_e && (bubble_cnt_q != C_CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q        <= RESET_PC;
      instr_d_q    <= '0;
      valid_d_q    <= 1'b0;
      ra1_e_q      <= '0;
      ra2_e_q      <= '0;
      wa3_e_q      <= '0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      memwrite_e_q <= 1'b0;
      pcsrc_e_q    <= 1'b0;
      branch_e_q   <= 1'b0;
      valid_e_q    <= 1'b0;
      wa3_m_q      <= '0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      pcsrc_m_q    <= 1'b0;
      valid_m_q    <= 1'b0;
      wa3_w_q      <= '0;
      regwrite_w_q <= 1'b0;
      pcsrc_w_q    <= 1'b0;
      valid_w_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      pcf_q        <= pcf_d;
      instr_d_q    <= instr_d_d;
      valid_d_q    <= valid_d_d;
      ra1_e_q      <= ra1_e_d;
      ra2_e_q      <= ra2_e_d;
      wa3_e_q      <= wa3_e_d;
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      memwrite_e_q <= memwrite_e_d;
      pcsrc_e_q    <= pcsrc_e_d;
      branch_e_q   <= branch_e_d;
      valid_e_q    <= valid_e_d;
      wa3_m_q      <= wa3_m_d;
      regwrite_m_q <= regwrite_m_d;
      memwrite_m_q <= memwrite_m_d;
      pcsrc_m_q    <= pcsrc_m_d;
      valid_m_q    <= valid_m_d;
      wa3_w_q      <= wa3_w_d;
      regwrite_w_q <= regwrite_w_d;
      pcsrc_w_q    <= pcsrc_w_d;
      valid_w_q    <= valid_w_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign PCF          = pcf_q;
  assign InstrD       = instr_d_q;
  assign RA1E         = ra1_e_q;
  assign RA2E         = ra2_e_q;
  assign WA3E         = wa3_e_q;
  assign WA3M         = wa3_m_q;
  assign WA3W         = wa3_w_q;
  assign RegWriteM    = regwrite_m_q;
  assign RegWriteW    = regwrite_w_q;
  assign MemtoRegE    = memtoreg_e_q;
  assign MemWriteM    = memwrite_m_q;
  assign PCSrcW       = pcsrc_w_q;
  assign BranchTakenE = branch_e_q & CondExE & valid_e_q;
  assign ValidD       = valid_d_q;
  assign ValidE       = valid_e_q;
  assign ValidM       = valid_m_q;
  assign ValidW       = valid_w_q;
  assign BubbleCnt    = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_regs
// Purpose  : Directed checks of pipe_stage_regs: reset, straight-line flow,
//            load-use stall, taken branch, failed condition, flush/stall
//            priority and bubble counter saturation (second instance, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_regs;

  localparam logic [31:0] C_IA = 32'hA000_0001;
  localparam logic [31:0] C_IB = 32'hB000_0002;
  localparam logic [31:0] C_IC = 32'hC000_0003;
  localparam logic [31:0] C_ID = 32'hD000_0004;
  localparam logic [31:0] C_IE = 32'hE000_0005;
  localparam logic [31:0] C_IF = 32'hF000_0006;
  localparam logic [31:0] C_IG = 32'h2222_2222;
  localparam logic [31:0] C_IH = 32'h3333_3333;

  logic        clk, rst_n;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, CondExE;

  logic [31:0] PCF, InstrD;
  logic [3:0]  RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE, MemWriteM, PCSrcW, BranchTakenE;
  logic        ValidD, ValidE, ValidM, ValidW;
  logic [15:0] BubbleCnt;

  logic [31:0] s_PCF, s_InstrD;
  logic [3:0]  s_RA1E, s_RA2E, s_WA3E, s_WA3M, s_WA3W;
  logic        s_RegWriteM, s_RegWriteW, s_MemtoRegE, s_MemWriteM, s_PCSrcW;
  logic        s_BranchTakenE, s_ValidD, s_ValidE, s_ValidM, s_ValidW;
  logic [1:0]  s_BubbleCnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_regs u_dut (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .PCSrcD(PCSrcD), .BranchD(BranchD), .CondExE(CondExE),
    .PCF(PCF), .InstrD(InstrD),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .MemWriteM(MemWriteM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .ValidD(ValidD), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
    .BubbleCnt(BubbleCnt)
  );

  pipe_stage_regs #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .PCSrcD(PCSrcD), .BranchD(BranchD), .CondExE(CondExE),
    .PCF(s_PCF), .InstrD(s_InstrD),
    .RA1E(s_RA1E), .RA2E(s_RA2E), .WA3E(s_WA3E), .WA3M(s_WA3M), .WA3W(s_WA3W),
    .RegWriteM(s_RegWriteM), .RegWriteW(s_RegWriteW), .MemtoRegE(s_MemtoRegE),
    .MemWriteM(s_MemWriteM), .PCSrcW(s_PCSrcW), .BranchTakenE(s_BranchTakenE),
    .ValidD(s_ValidD), .ValidE(s_ValidE), .ValidM(s_ValidM), .ValidW(s_ValidW),
    .BubbleCnt(s_BubbleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // haz   = {StallF, StallD, FlushD, FlushE}
  // addr  = {RA1D, RA2D, WA3D}
  // ctl   = {RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, CondExE}
  // e_addr  = {RA1E, RA2E, WA3E, WA3M, WA3W}
  // e_flags = {ValidD, ValidE, ValidM, ValidW, RegWriteM, RegWriteW, MemtoRegE, MemWriteM}
  // e_pb    = {PCSrcW, BranchTakenE}
  typedef struct packed {
    logic [3:0]  haz;
    logic [31:0] pcn;
    logic [31:0] instr;
    logic [11:0] addr;
    logic [5:0]  ctl;
    logic [31:0] e_pcf;
    logic [31:0] e_instrd;
    logic [19:0] e_addr;
    logic [7:0]  e_flags;
    logic [1:0]  e_pb;
    logic [15:0] e_bub;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                         input logic rw, input logic m2r, input logic mw, input logic pcs,
                         input logic br);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; PCSrcD = pcs; BranchD = br;
  endtask

  initial begin
    logic [109:0] act;
    logic [109:0] exp;

    // Straight-line A,B,C,D then E; CondExE=0 on the last row fails C in E.
    vecs[0] = '{4'b0000, 32'h04, C_IA, 12'h000, 6'b000000, 32'h04, C_IA,
                20'h00000, 8'b1000_0000, 2'b00, 16'd1};
    vecs[1] = '{4'b0000, 32'h08, C_IB, 12'h127, 6'b100001, 32'h08, C_IB,
                20'h12700, 8'b1100_0000, 2'b00, 16'd1};
    vecs[2] = '{4'b0000, 32'h0C, C_IC, 12'h348, 6'b100001, 32'h0C, C_IC,
                20'h34870, 8'b1110_1000, 2'b00, 16'd1};
    vecs[3] = '{4'b0000, 32'h10, C_ID, 12'h565, 6'b100001, 32'h10, C_ID,
                20'h56587, 8'b1111_1100, 2'b00, 16'd1};
    vecs[4] = '{4'b0000, 32'h14, C_IE, 12'h000, 6'b000000, 32'h14, C_IE,
                20'h00058, 8'b1111_0100, 2'b00, 16'd1};

    rst_n = 1'b0;
    {StallF, StallD, FlushD, FlushE} = 4'b0000;
    PCNextF = '0; InstrF = '0; CondExE = 1'b0;
    set_dec(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("reset_pcf", PCF, 32'h0);
    chk("reset_valids", {ValidD, ValidE, ValidM, ValidW}, 4'b0000);
    chk("reset_bubble", BubbleCnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      {StallF, StallD, FlushD, FlushE} = vecs[i].haz;
      PCNextF = vecs[i].pcn;
      InstrF  = vecs[i].instr;
      {RA1D, RA2D, WA3D} = vecs[i].addr;
      {RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, CondExE} = vecs[i].ctl;
      step();
      act = {PCF, InstrD, RA1E, RA2E, WA3E, WA3M, WA3W,
             ValidD, ValidE, ValidM, ValidW, RegWriteM, RegWriteW, MemtoRegE, MemWriteM,
             PCSrcW, BranchTakenE, BubbleCnt};
      exp = {vecs[i].e_pcf, vecs[i].e_instrd, vecs[i].e_addr, vecs[i].e_flags,
             vecs[i].e_pb, vecs[i].e_bub};
      chk($sformatf("row%0d", i), act, exp);
    end

    // Load-use: E (load r3) in D, then F (uses r3) stalls one cycle.
    set_dec(4'h9, 4'h0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    PCNextF = 32'h18; InstrF = C_IF; CondExE = 1'b1;
    step();
    chk("load_memtoregE", MemtoRegE, 1'b1);
    set_dec(4'h3, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    {StallF, StallD, FlushE} = 3'b111;
    PCNextF = 32'h1C; InstrF = 32'h1111_1111;
    step();
    chk("lu_pcf_hold", PCF, 32'h18);
    chk("lu_instrd_hold", InstrD, C_IF);
    chk("lu_memtoregE", MemtoRegE, 1'b0);
    chk("lu_validE", ValidE, 1'b0);
    chk("lu_bubble", BubbleCnt, 16'd2);
    chk("lu_wa3m", {ValidM, WA3M}, {1'b1, 4'h3});
    {StallF, StallD, FlushE} = 3'b000;
    InstrF = C_IG;
    step();
    chk("lu_resume", {PCF, InstrD, RA1E, ValidE}, {32'h1C, C_IG, 4'h3, 1'b1});
    chk("lu_resume_bubble", BubbleCnt, 16'd2);

    // Taken branch: G is a branch, evaluated in E.
    set_dec(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    CondExE = 1'b0; PCNextF = 32'h20; InstrF = C_IH;
    step();
    chk("br_cond0", BranchTakenE, 1'b0);
    CondExE = 1'b1;
    #1;
    chk("br_taken_comb", BranchTakenE, 1'b1);
    set_dec(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    {FlushD, FlushE} = 2'b11;
    PCNextF = 32'h100; InstrF = 32'h6666_6666;
    step();
    chk("br_flush_valid", {ValidD, ValidE, ValidM}, 3'b001);
    chk("br_flush_instr", InstrD, 32'h0);
    chk("br_pcf", PCF, 32'h100);
    chk("br_taken_clr", BranchTakenE, 1'b0);
    chk("br_bubble", BubbleCnt, 16'd3);
    chk("sat_at_max", s_BubbleCnt, 2'd3);

    // Flushed D enters E as a bubble; its side-effect controls must be dropped.
    {FlushD, FlushE} = 2'b00;
    set_dec(4'h0, 4'h0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    CondExE = 1'b0; PCNextF = 32'h104; InstrF = 32'h4444_4444;
    step();
    chk("bub_valid", {ValidD, ValidE}, 2'b10);
    chk("bub_cnt", BubbleCnt, 16'd4);
    chk("sat_no_wrap", s_BubbleCnt, 2'd3);
    set_dec(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    CondExE = 1'b1;
    step();
    chk("bub_gated_ctl", {RegWriteM, MemWriteM, ValidM}, 3'b000);

    // Flush over stall priority in D.
    {StallD, FlushD} = 2'b11;
    step();
    chk("prio_flush", {InstrD, ValidD}, {32'h0, 1'b0});
    {StallD, FlushD} = 2'b00;
    InstrF = 32'h5555_5555;
    step();
    set_dec(4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_dec(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    CondExE = 1'b1;
    step();
    chk("mw_m", {MemWriteM, WA3M}, {1'b1, 4'hF});
    step();
    chk("wb_stage", {PCSrcW, RegWriteW, WA3W}, {1'b1, 1'b1, 4'hF});
    chk("wb_bubble", BubbleCnt, 16'd5);

    // Five consecutive flushes of E.
    FlushE = 1'b1;
    for (int k = 0; k < 5; k++) step();
    FlushE = 1'b0;
    chk("flush5_cnt", BubbleCnt, 16'd10);
    chk("flush5_sat", s_BubbleCnt, 2'd3);

    // Asynchronous reset in the middle of a cycle.
    PCNextF = 32'h40; InstrF = 32'h7777_7777;
    step();
    step();
    chk("pre_rst_pcf", PCF, 32'h40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pcf", PCF, 32'h0);
    chk("arst_state", {InstrD, ValidD, ValidE, ValidM, ValidW, RegWriteM, RegWriteW,
                       MemtoRegE, MemWriteM, PCSrcW, WA3W},
        {32'h0, 9'h0, 4'h0});
    chk("arst_bubble", {BubbleCnt, s_BubbleCnt}, 18'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
